// File: rtl/blake2_host_ctrl.sv
// Host-side byte sequencer for a BLAKE2s core: parses CONFIG, streams and pads
// message blocks to the core, and returns the first nn digest bytes to the host.
module blake2_host_ctrl #(
  parameter int BLOCK_BYTES = 64,
  parameter int HASH_BYTES  = 32,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data_i,
  input  logic             in_cmd_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [7:0]       core_data_o,
  output logic             core_valid_o,
  input  logic             core_ready_i,
  output logic             core_first_o,
  output logic             core_last_o,
  output logic [LEN_W-1:0] core_len_o,
  output logic [5:0]       core_nn_o,
  output logic             core_abort_o,
  input  logic [7:0]       res_data_i,
  input  logic             res_valid_i,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int BC_W = $clog2(BLOCK_BYTES);
  localparam int RC_W = $clog2(HASH_BYTES);
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLOCK_BYTES - 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(HASH_BYTES - 1);
  localparam logic [7:0] CMD_CONFIG = 8'h01;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CFG_NN   = 3'd1;
  localparam logic [2:0] S_CFG_LLO  = 3'd2;
  localparam logic [2:0] S_CFG_LHI  = 3'd3;
  localparam logic [2:0] S_LOAD     = 3'd4;
  localparam logic [2:0] S_PAD      = 3'd5;
  localparam logic [2:0] S_WAIT_RES = 3'd6;
  localparam logic [2:0] S_RES      = 3'd7;

  logic [2:0]       state;
  logic [BC_W-1:0]  bc;
  logic [LEN_W-1:0] rem;
  logic [RC_W-1:0]  rc;
  logic             first_q;
  logic [LEN_W:0]   room;
  logic             last_blk;
  logic [LEN_W-1:0] ll_new;

  // The current block is final when the remaining bytes fit in what is left of it.
  assign room     = (LEN_W+1)'(BLOCK_BYTES) - {{(LEN_W+1-BC_W){1'b0}}, bc};
  assign last_blk = ({1'b0, rem} <= room);
  assign ll_new   = LEN_W'({in_data_i, core_len_o[7:0]});
  assign busy_o   = (state != S_IDLE);

  always_comb begin
    in_ready_o   = 1'b0;
    core_valid_o = 1'b0;
    core_data_o  = 8'h00;
    core_first_o = 1'b0;
    core_last_o  = 1'b0;
    case (state)
      S_IDLE, S_CFG_NN, S_CFG_LLO, S_CFG_LHI: in_ready_o = 1'b1;
      S_LOAD: begin
        core_data_o  = in_data_i;
        core_valid_o = in_valid_i & ~in_cmd_i;
        in_ready_o   = in_cmd_i | core_ready_i;
        core_first_o = first_q;
        core_last_o  = last_blk;
      end
      S_PAD: begin
        core_valid_o = 1'b1;
        core_first_o = first_q;
        core_last_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bc           <= '0;
      rem          <= '0;
      rc           <= '0;
      first_q      <= 1'b0;
      core_len_o   <= '0;
      core_nn_o    <= '0;
      core_abort_o <= 1'b0;
      out_data_o   <= 8'h00;
      out_valid_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      out_valid_o  <= 1'b0;
      done_o       <= 1'b0;
      core_abort_o <= 1'b0;
      if (res_valid_i && state != S_WAIT_RES && state != S_RES) err_o <= 1'b1;
      case (state)
        S_IDLE: if (in_valid_i) begin
          if (in_cmd_i && in_data_i == CMD_CONFIG) begin
            err_o <= 1'b0;
            state <= S_CFG_NN;
          end else begin
            err_o <= 1'b1;
          end
        end
        S_CFG_NN: if (in_valid_i) begin
          if (in_cmd_i || in_data_i == 8'h00 || in_data_i > 8'(HASH_BYTES)) begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end else begin
            core_nn_o <= in_data_i[5:0];
            state     <= S_CFG_LLO;
          end
        end
        S_CFG_LLO: if (in_valid_i) begin
          if (in_cmd_i) begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end else begin
            core_len_o[7:0] <= in_data_i;
            state           <= S_CFG_LHI;
          end
        end
        S_CFG_LHI: if (in_valid_i) begin
          if (in_cmd_i) begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end else begin
            core_len_o <= ll_new;
            bc         <= '0;
            rc         <= '0;
            rem        <= ll_new;
            first_q    <= 1'b1;
            state      <= (ll_new == '0) ? S_PAD : S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid_i && in_cmd_i) begin
            core_abort_o <= 1'b1;
            err_o        <= 1'b1;
            state        <= S_IDLE;
          end else if (core_valid_o && core_ready_i) begin
            bc  <= bc + 1'b1;
            rem <= rem - 1'b1;
            if (bc == BC_MAX) first_q <= 1'b0;
            if (rem == LEN_W'(1)) state <= (bc == BC_MAX) ? S_WAIT_RES : S_PAD;
          end
        end
        S_PAD: if (core_ready_i) begin
          bc <= bc + 1'b1;
          if (bc == BC_MAX) begin
            first_q <= 1'b0;
            state   <= S_WAIT_RES;
          end
        end
        S_WAIT_RES, S_RES: if (res_valid_i) begin
          if ({1'b0, rc} < core_nn_o) begin
            out_data_o  <= res_data_i;
            out_valid_o <= 1'b1;
          end
          if (rc == RC_MAX) begin
            rc     <= '0;
            done_o <= 1'b1;
            state  <= S_IDLE;
          end else begin
            rc    <= rc + 1'b1;
            state <= S_RES;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_host_ctrl.sv
// Self-checking bench for blake2_host_ctrl: random messages and digests checked
// against a block/padding/flag model built from message length alone.
module tb_blake2_host_ctrl;

  localparam int BB = 64;
  localparam int HB = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data_i = 8'h00;
  logic        in_cmd_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  core_data_o;
  logic        core_valid_o;
  logic        core_ready_i = 1'b1;
  logic        core_first_o;
  logic        core_last_o;
  logic [15:0] core_len_o;
  logic [5:0]  core_nn_o;
  logic        core_abort_o;
  logic [7:0]  res_data_i = 8'h00;
  logic        res_valid_i = 1'b0;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  blake2_host_ctrl #(.BLOCK_BYTES(BB), .HASH_BYTES(HB), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data_i), .in_cmd_i(in_cmd_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .core_data_o(core_data_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_first_o(core_first_o), .core_last_o(core_last_o), .core_len_o(core_len_o),
    .core_nn_o(core_nn_o), .core_abort_o(core_abort_o),
    .res_data_i(res_data_i), .res_valid_i(res_valid_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int abort_cnt = 0;
  int last_res_cyc = 0;
  int track_err = 0;
  bit in_load = 1'b0;
  bit rnd_rdy = 1'b0;
  logic [9:0] cq[$];
  logic [7:0] oq[$];
  logic [7:0] msg[0:255];
  logic [7:0] res[0:HB-1];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (core_valid_o && core_ready_i) cq.push_back({core_data_o, core_first_o, core_last_o});
    if (out_valid_o) oq.push_back(out_data_o);
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (core_abort_o) abort_cnt++;
    if (res_valid_i) last_res_cyc = cyc;
    if (in_load && in_valid_i && !in_cmd_i && in_ready_o !== core_ready_i) track_err++;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      core_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input bit cmd, input logic [7:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid_i = 1'b1; in_cmd_i = cmd; in_data_i = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready_o) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0; in_cmd_i = 1'b0;
    if (!ok) begin
      miscompares++;
      $display("FAIL host_accept: byte %h got in_ready 0, required 1 within 300 cycles", d);
    end
  endtask

  task automatic send_config(input int nn, input int ll);
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, nn[7:0]);
    send_byte(1'b0, ll[7:0]);
    send_byte(1'b0, ll[15:8]);
  endtask

  task automatic idle_outputs_check(input string name);
    logic [10:0] got;
    got = {busy_o, core_valid_o, core_first_o, core_last_o, out_valid_o, done_o, err_o,
           core_abort_o, core_len_o != 16'h0, core_nn_o != 6'h0, out_data_o != 8'h0};
    vectors++;
    if (got !== 11'h0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: outputs %b in_ready %b, required 00000000000 and 1", name, got, in_ready_o);
    end
  endtask

  // Full hash transaction: config, message, core stream check, digest return check.
  task automatic run_hash(input int nn, input int ll, input bit rnd, input string name);
    int total;
    int blocks;
    logic [9:0] exp;
    cq.delete(); oq.delete();
    done_cnt = 0; abort_cnt = 0; track_err = 0;
    send_config(nn, ll);
    vectors++;
    if (core_len_o !== ll[15:0] || core_nn_o !== nn[5:0]) begin
      miscompares++;
      $display("FAIL %s_cfg: len %0d nn %0d, required %0d %0d", name, core_len_o, core_nn_o, ll, nn);
    end
    rnd_rdy = rnd;
    in_load = 1'b1;
    for (int k = 0; k < ll; k++) send_byte(1'b0, msg[k]);
    in_load = 1'b0;
    blocks = (ll == 0) ? 1 : (ll + BB - 1) / BB;
    total = blocks * BB;
    for (int i = 0; i < 3000 && cq.size() < total; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    rnd_rdy = 1'b0;
    @(negedge clk);
    vectors++;
    if (cq.size() != total) begin
      miscompares++;
      $display("FAIL %s_count: core got %0d bytes, required %0d", name, cq.size(), total);
    end
    for (int k = 0; k < cq.size() && k < total; k++) begin
      exp = {(k < ll) ? msg[k] : 8'h00, k < BB, (k / BB) == (blocks - 1)};
      vectors++;
      if (cq[k] !== exp) begin
        miscompares++;
        $display("FAIL %s_stream[%0d]: data/first/last %h/%b/%b, required %h/%b/%b", name, k,
                 cq[k][9:2], cq[k][1], cq[k][0], exp[9:2], exp[1], exp[0]);
      end
    end
    vectors++;
    if (track_err != 0 || in_ready_o !== 1'b0 || busy_o !== 1'b1 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_wait: track_err %0d in_ready %b busy %b err %b, required 0 0 1 0",
               name, track_err, in_ready_o, busy_o, err_o);
    end
    for (int r = 0; r < HB; r++) res[r] = 8'($urandom);
    @(posedge clk); #1;
    for (int r = 0; r < HB; r++) begin
      res_valid_i = 1'b0;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      res_valid_i = 1'b1; res_data_i = res[r];
      @(posedge clk); #1;
    end
    res_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (oq.size() != nn) begin
      miscompares++;
      $display("FAIL %s_out_count: host got %0d digest bytes, required %0d", name, oq.size(), nn);
    end
    for (int i = 0; i < oq.size() && i < nn; i++) begin
      vectors++;
      if (oq[i] !== res[i]) begin
        miscompares++;
        $display("FAIL %s_out[%0d]: got %h, required %h", name, i, oq[i], res[i]);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != last_res_cyc + 1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: pulses %0d at cyc %0d (last res %0d) busy %b err %b, required 1 at +1, 0, 0",
               name, done_cnt, done_cyc, last_res_cyc, busy_o, err_o);
    end
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) msg[k] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle_outputs_check("reset");
  endtask

  task automatic test_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_hash(32, 3, 1'b0, "abc");
  endtask

  task automatic test_block_boundary();
    fill_random(64);
    run_hash(32, 64, 1'b0, "ll64");
    fill_random(65);
    run_hash(20, 65, 1'b0, "ll65");
  endtask

  task automatic test_empty();
    run_hash(16, 0, 1'b0, "ll0");
  endtask

  task automatic test_back_pressure();
    fill_random(130);
    run_hash(HB, 130, 1'b1, "bp130");
    fill_random(200);
    run_hash(1, 200, 1'b1, "bp200");
  endtask

  task automatic test_abort();
    cq.delete(); abort_cnt = 0;
    fill_random(10);
    send_config(32, 100);
    for (int k = 0; k < 10; k++) send_byte(1'b0, msg[k]);
    send_byte(1'b1, 8'h55);
    repeat (3) @(negedge clk);
    vectors++;
    if (abort_cnt != 1 || err_o !== 1'b1 || busy_o !== 1'b0 || cq.size() != 10) begin
      miscompares++;
      $display("FAIL abort: pulses %0d err %b busy %b core bytes %0d, required 1 1 0 10",
               abort_cnt, err_o, busy_o, cq.size());
    end
  endtask

  task automatic test_bad_cfg();
    send_byte(1'b1, 8'h01);
    vectors++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_clears_err: err %b busy %b, required 0 1", err_o, busy_o);
    end
    send_byte(1'b0, 8'h00);
    vectors++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL nn0: err %b busy %b, required 1 0", err_o, busy_o);
    end
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'd33);
    vectors++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL nn33: err %b busy %b, required 1 0", err_o, busy_o);
    end
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'd8);
    @(posedge clk); #1 res_valid_i = 1'b1;
    @(posedge clk); #1 res_valid_i = 1'b0;
    vectors++;
    if (err_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_res: err %b busy %b, required 1 1", err_o, busy_o);
    end
    send_byte(1'b1, 8'h02);
    vectors++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_in_cfg: err %b busy %b, required 1 0", err_o, busy_o);
    end
  endtask

  task automatic test_reset_mid_pad();
    cq.delete();
    msg[0] = 8'h11; msg[1] = 8'h22; msg[2] = 8'h33;
    send_config(32, 3);
    for (int k = 0; k < 3; k++) send_byte(1'b0, msg[k]);
    for (int i = 0; i < 200 && cq.size() < 20; i++) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    idle_outputs_check("reset_mid_pad");
    fill_random(5);
    run_hash(32, 5, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_block_boundary();
    test_empty();
    test_back_pressure();
    test_abort();
    test_bad_cfg();
    test_reset_mid_pad();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
